// File: rtl/leb128_encoder_if.sv
// Value-in / byte-out stream bundle for the LEB128 encoder.
// The encoder takes the slave modport; the producer/consumer side takes master.
interface leb128_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_value;
  logic        in_signed;
  logic        in_width64;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [3:0]  out_index;

  modport slave (
    input  in_valid, in_value, in_signed, in_width64, out_ready,
    output in_ready, out_valid, out_data, out_last, out_index
  );

  modport master (
    output in_valid, in_value, in_signed, in_width64, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_index
  );
endinterface

// File: rtl/leb128_encoder.sv
// Serialises one integer per transaction into ULEB128/SLEB128 bytes, one byte
// per cycle, with back-to-back acceptance on the final byte.
module leb128_encoder #(
  parameter bit USE_64B = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  leb128_encoder_if.slave  bus
);
  localparam int W = USE_64B ? 64 : 32;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t              state, state_nxt;
  logic [W-1:0]        v, v_load, nxt, lshr;
  logic signed [W-1:0] sv, ashr;
  logic [63:0]         ext32;
  logic                sgn, done, accept, xfer;
  logic [3:0]          idx;

  // Arithmetic shift kept in its own signed expression so it never degrades
  // to a logical shift inside a mixed-signedness ternary.
  assign sv   = v;
  assign ashr = sv >>> 7;
  assign lshr = v >> 7;
  assign nxt  = sgn ? ashr : lshr;
  assign done = sgn ? ((nxt == '0 && !v[6]) || (nxt == '1 && v[6])) : (nxt == '0);

  assign ext32  = bus.in_signed ? {{32{bus.in_value[31]}}, bus.in_value[31:0]}
                                : {32'd0, bus.in_value[31:0]};
  assign v_load = (USE_64B && bus.in_width64) ? bus.in_value[W-1:0] : ext32[W-1:0];

  assign xfer   = bus.out_valid && bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = EMIT;
      EMIT: if (xfer && done) state_nxt = accept ? EMIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid = (state == EMIT);
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    bus.out_index = '0;
    if (state == EMIT) begin
      bus.out_data  = {~done, v[6:0]};
      bus.out_last  = done;
      bus.out_index = idx;
    end
    bus.in_ready = (state == IDLE) || ((state == EMIT) && done && bus.out_ready);
  end

  // Accept has priority: in EMIT it only fires together with the last transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v   <= '0;
      sgn <= 1'b0;
      idx <= '0;
    end else if (accept) begin
      v   <= v_load;
      sgn <= bus.in_signed;
      idx <= '0;
    end else if (xfer && !done) begin
      v   <= nxt;
      idx <= idx + 4'd1;
    end
  end
endmodule

// File: tb/tb_leb128_encoder.sv
// Directed vector bench for leb128_encoder: table of values with hand-computed
// byte streams, plus backpressure, back-to-back and mid-stream reset sequences.
module tb_leb128_encoder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  leb128_encoder_if bus ();
  leb128_encoder #(.USE_64B(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [63:0]      value;
    logic             sgn;
    logic             w64;
    int               n;
    logic [0:9][7:0]  b;
  } vec_t;

  vec_t tv [13];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [63:0] value, input logic sgn, input logic w64);
    int t;
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.in_value   = value;
    bus.in_signed  = sgn;
    bus.in_width64 = w64;
    t = 0;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("accept_ready", {63'd0, bus.in_ready}, 64'd1);
  endtask

  // Runs with out_ready high; first negedge after accept must already show a byte.
  task automatic collect(input string tag, input int n, input logic [0:9][7:0] b);
    int k;
    int guard;
    logic last;
    k = 0;
    guard = 0;
    last = 1'b0;
    while (!last && guard < 30) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (guard == 0) chk({tag, "_latency"}, {63'd0, bus.out_valid}, 64'd1);
      if (bus.out_valid) begin
        chk({tag, "_data"},  {56'd0, bus.out_data},  {56'd0, (k < 10) ? b[k] : 8'h00});
        chk({tag, "_index"}, {60'd0, bus.out_index}, k[63:0]);
        chk({tag, "_last"},  {63'd0, bus.out_last},  {63'd0, (k == n - 1)});
        if (bus.out_last) chk({tag, "_ready_on_last"}, {63'd0, bus.in_ready}, 64'd1);
        last = bus.out_last;
        k++;
      end
      guard++;
    end
    chk({tag, "_count"}, k[63:0], n[63:0]);
  endtask

  initial begin
    int k, c;
    logic last;
    logic [0:9][7:0] exp_b;

    bus.in_valid   = 1'b0;
    bus.in_value   = '0;
    bus.in_signed  = 1'b0;
    bus.in_width64 = 1'b0;
    bus.out_ready  = 1'b1;

    tv[0]  = '{64'd0,                   1'b0, 1'b0, 1,  {8'h00, 72'd0}};
    tv[1]  = '{64'd624485,              1'b0, 1'b0, 3,  {8'hE5, 8'h8E, 8'h26, 56'd0}};
    tv[2]  = '{64'hFFFF_FFFF_FFFE_1DC0, 1'b1, 1'b0, 3,  {8'hC0, 8'hBB, 8'h78, 56'd0}};
    tv[3]  = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1,  {8'h7F, 72'd0}};
    tv[4]  = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 5,  {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 40'd0}};
    tv[5]  = '{64'hC000_0000_0000_0000, 1'b1, 1'b1, 9,  {{8{8'h80}}, 8'h40, 8'd0}};
    tv[6]  = '{64'hC000_0000_0000_0000, 1'b0, 1'b1, 10, {{8{8'h80}}, 8'hC0, 8'h01}};
    tv[7]  = '{64'd127,                 1'b0, 1'b0, 1,  {8'h7F, 72'd0}};
    tv[8]  = '{64'hDEAD_BEEF_0000_0080, 1'b0, 1'b0, 2,  {8'h80, 8'h01, 64'd0}};
    tv[9]  = '{64'd64,                  1'b1, 1'b0, 2,  {8'hC0, 8'h00, 64'd0}};
    tv[10] = '{64'hFFFF_FFFF_FFFF_FFC0, 1'b1, 1'b1, 1,  {8'h40, 72'd0}};
    tv[11] = '{64'h8000_0000_0000_0000, 1'b1, 1'b1, 10, {{9{8'h80}}, 8'h7F}};
    tv[12] = '{64'h0000_0000_8000_0000, 1'b1, 1'b0, 5,  {8'h80, 8'h80, 8'h80, 8'h80, 8'h78, 40'd0}};

    // Reset state
    #2;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_data",  {56'd0, bus.out_data},  64'd0);
    chk("rst_out_last",  {63'd0, bus.out_last},  64'd0);
    chk("rst_out_index", {60'd0, bus.out_index}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    for (int i = 0; i < 13; i++) begin
      send(tv[i].value, tv[i].sgn, tv[i].w64);
      collect($sformatf("vec%0d", i), tv[i].n, tv[i].b);
    end

    // Backpressure: out_ready cycles 1,0,0 while 624485 drains.
    exp_b = {8'hE5, 8'h8E, 8'h26, 56'd0};
    send(64'd624485, 1'b0, 1'b0);
    k = 0;
    c = 0;
    last = 1'b0;
    while (!last && c < 30) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = (c % 3 == 0);
      #1;
      if (c == 0) chk("bp_valid_first", {63'd0, bus.out_valid}, 64'd1);
      if (bus.out_valid && k < 3) begin
        chk("bp_data",  {56'd0, bus.out_data},  {56'd0, exp_b[k]});
        chk("bp_index", {60'd0, bus.out_index}, k[63:0]);
        chk("bp_last",  {63'd0, bus.out_last},  {63'd0, (k == 2)});
        if (bus.out_ready) begin
          last = bus.out_last;
          k++;
        end
      end
      c++;
    end
    chk("bp_count", k[63:0], 64'd3);
    @(negedge clk);
    bus.out_ready = 1'b1;
    chk("bp_idle_after", {63'd0, bus.out_valid}, 64'd0);

    // Back-to-back: next value offered on the last byte, no bubble expected.
    send(64'd128, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("b2b_a0", {56'd0, bus.out_data}, 64'h80);
    @(negedge clk);
    chk("b2b_a1",      {56'd0, bus.out_data}, 64'h01);
    chk("b2b_a1_last", {63'd0, bus.out_last}, 64'd1);
    chk("b2b_ready",   {63'd0, bus.in_ready}, 64'd1);
    bus.in_valid   = 1'b1;
    bus.in_value   = 64'd624485;
    bus.in_signed  = 1'b0;
    bus.in_width64 = 1'b0;
    collect("b2b_b", 3, {8'hE5, 8'h8E, 8'h26, 56'd0});

    // Asynchronous reset while byte 2 of a 10-byte encoding is on the bus.
    send(64'hC000_0000_0000_0000, 1'b0, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ar_pre_index", {60'd0, bus.out_index}, 64'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("ar_out_index", {60'd0, bus.out_index}, 64'd0);
    chk("ar_out_data",  {56'd0, bus.out_data},  64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ar_in_ready", {63'd0, bus.in_ready}, 64'd1);
    send(64'd5, 1'b0, 1'b0);
    collect("ar_after", 1, {8'h05, 72'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/leb128_encoder.md
Name: leb128_encoder

Overview:
Serialises one 32- or 64-bit integer per transaction into WebAssembly LEB128 bytes, signed (SLEB128) or unsigned (ULEB128), one byte per cycle on a valid/ready byte stream. It is the writer counterpart of the CPU's immediate decoder. It feeds bytecode assemblers, the stack/result dump path and self-check benches that build ROM images for the CPU.

Parameters:
USE_64B, 1, 1 = 64-bit datapath and in_width64 honoured; 0 = 32-bit datapath, in_width64 forced to 0, in_value[63:32] ignored.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous active-low reset.
in_valid  input  1  source offers a value.
in_ready  output  1  encoder accepts the value this cycle.
in_value  input  64  integer to encode.
in_signed  input  1  1 = SLEB128, 0 = ULEB128.
in_width64  input  1  1 = 64-bit operand, 0 = 32-bit operand (low 32 bits).
out_valid  output  1  out_data is valid.
out_ready  input  1  sink takes the byte this cycle.
out_data  output  8  encoded byte: bit7 = continuation, bits6:0 = payload.
out_last  output  1  final byte of the current value.
out_index  output  4  index of the current byte within the value, 0..9.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. out_valid=0, out_data=0, out_last=0, out_index=0. in_ready=1 once reset deasserts. A value in flight is discarded with no partial completion.
- States are IDLE and EMIT. in_ready = IDLE or (EMIT and out_valid and out_last and out_ready).
- Accept: in_valid and in_ready.
  - Operand latched into 64-bit shift register V.
  - For 32-bit operands, V = sign-extend(in_value[31:0]) if in_signed, else zero-extend.
  - Next state EMIT. The first byte is presented on out_valid the following cycle, so latency is 1.
- Byte formation from current V:
  - payload = V[6:0].
  - nxt = V >>> 7 (arithmetic) if signed, else V >> 7 (logical).
  - Unsigned: done = (nxt == 0).
  - Signed: done = (nxt == 0 and V[6] == 0) or (nxt == all-ones and V[6] == 1).
  - out_data = {~done, payload}. out_last = done.
- Byte transfer: out_valid and out_ready.
  - If not last: V <= nxt, out_index++.
  - If last: return to IDLE, or accept the next value in the same cycle (back-to-back, no bubble).
- Backpressure: while out_valid and not out_ready, out_data, out_last and out_index hold stable. out_valid must not drop until the byte is transferred.
- Byte count: a 32-bit operand produces at most 5 bytes, a 64-bit operand at most 10 bytes. The termination rule yields the minimal encoding.
- Throughput: 1 byte per cycle with out_ready held high.
- in_value is sampled only on accept; changes while in EMIT are ignored.
- USE_64B=0: V is 32 bits, maximum 5 bytes, in_width64 is a don't-care.

Test Plan:
- Unsigned 0, 32-bit → single byte 0x00, out_last=1, out_index=0. in_ready is high in the same cycle as that byte's transfer.
- Unsigned 624485 → E5 8E 26 on consecutive cycles. out_last only on 0x26. out_index steps 0,1,2.
- Signed -123456, 32-bit → C0 BB 78. Then, with in_value=64'hFFFFFFFF_FFFFFFFF and in_width64=0: signed → 7F; unsigned → FF FF FF FF 0F.
- 64-bit 0xC000000000000000:
  - signed → 80×8, 40 (9 bytes).
  - unsigned → 80×8, C0, 01 (10 bytes, out_index reaches 9).
- Backpressure: encode 624485 with out_ready toggled 1,0,0,1,… → each byte held stable while stalled. Sequence unchanged, no duplicates or drops. Two back-to-back values complete with no idle cycle between them.
- Reset pulled low during byte 2 of the 0xC000000000000000 encoding (any phase of clk) → out_valid=0 immediately, in_ready=1 after release. A new value 5 then encodes as 05 only.
